mm_operand_loader: RTL and testbench
====================================

MM_OPERAND_LOADER -- requirements
Module: mm_operand_loader

Interface
REQ-001 Parameter WIDTH, default 256, operand bit width.
REQ-002 Parameter OPERANDS, default 3, operands per load, written in order A, B, M.
REQ-003 Parameter BASE_ADDR, default 0, BRAM word address of limb 0 of operand 0.
REQ-004 Localparams: s = (WIDTH+1)/17+1 limbs per operand; NW = ceil(WIDTH/32) input words per operand.
REQ-005 clock_i  in  1  sole clock, rising edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 load_i  in  1  one-cycle pulse that starts a load; sampled only in IDLE.
REQ-008 s_data_i  in  32  operand word, least-significant word first.
REQ-009 s_valid_i  in  1  s_data_i valid.
REQ-010 s_ready_o  out  1  word accepted when s_valid_i and s_ready_o are both high at a rising edge.
REQ-011 BRAM_addr_o  out  32  BRAM word address (not a byte address).
REQ-012 BRAM_din_o  out  17  limb write data.
REQ-013 BRAM_we_o  out  1  write enable.
REQ-014 BRAM_en_o  out  1  enable, equal to BRAM_we_o.
REQ-015 start_o  out  1  start pulse to the multiplier.
REQ-016 mm_done_i  in  1  multiplier completion pulse.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 done_o  out  1  one-cycle completion pulse.

Function
REQ-019 The FSM SHALL use the states IDLE, LOAD, START, WAIT and FIN; IDLE->LOAD on load_i; LOAD->START after the OPERANDS*s-th limb write; START->WAIT after one cycle; WAIT->FIN on mm_done_i; FIN->IDLE after one cycle.
REQ-020 start_o SHALL be high only in START, and done_o only in FIN, each for exactly one cycle.
REQ-021 The 49-bit repack buffer SHALL append each accepted word above its current fill and emit the low 17 bits as one limb per cycle whenever fill >= 17.
REQ-022 In the last word of each operand, bits above WIDTH SHALL be masked to zero before entry.
REQ-023 After the NW-th word of an operand, the buffer SHALL zero-pad until s limbs are emitted, then clear; no bits carry into the next operand.
REQ-024 s_ready_o SHALL be high only in LOAD, while words remain for the current operand and (fill − 17·emit_this_cycle) <= 17; it SHALL be low during padding.
REQ-025 The write of limb k of operand j SHALL drive BRAM_addr_o = BASE_ADDR + j*s + k, with BRAM_we_o registered, asserted the cycle after the buffer first holds the limb's bits.
REQ-026 At most one BRAM write SHALL occur per cycle, and none occur outside LOAD.
REQ-027 load_i outside IDLE and mm_done_i outside WAIT SHALL be ignored.
REQ-028 A stalled s_valid_i SHALL cause neither duplicated nor dropped limbs.

Reset
REQ-029 While reset_n_i is low, all outputs SHALL be 0, the FSM SHALL be IDLE, and buffer, fill, word and limb counters SHALL be 0, including mid-LOAD or mid-WAIT.
REQ-030 After reset, the next load SHALL restart at BASE_ADDR.

Configuration
REQ-031 With MM_LOADER_ERR_EN defined, an output err_o (1 bit) SHALL be added; it sets sticky on load_i outside IDLE or mm_done_i outside WAIT, and clears on reset or on an accepted load_i in IDLE.
REQ-032 Without MM_LOADER_ERR_EN, err_o and its logic SHALL be absent and the remaining behaviour SHALL be unchanged.

Verification (WIDTH=256, s=16, NW=8, OPERANDS=3, BASE_ADDR=0)
REQ-033 Reset: hold reset_n_i low for 3 cycles -> every output 0 and s_ready_o low.
REQ-034 Load A=1, B=2, M=2^255+1 -> exactly 48 writes; addr0=0x00001, addr1..15=0; addr16=0x00002; addr32=0x00001, addr47=0x00001.
REQ-035 Operand A all ones -> addr0..14=0x1FFFF and addr15=0x00001.
REQ-036 s_valid_i toggled 1-0-1-0 across the REQ-034 load -> identical 48 writes, no duplicate addresses.
REQ-037 After write 48, start_o pulses once; mm_done_i pulsed 100 cycles later -> done_o pulses the following cycle, then busy_o goes low.
REQ-038 reset_n_i asserted after 5 accepted words, then a new load -> the first write goes to addr0; with MM_LOADER_ERR_EN, load_i in WAIT -> err_o=1.

Source files
------------

// File: rtl/mm_operand_loader.sv
// Streams OPERANDS operands of WIDTH bits (32-bit words, LSW first) into BRAM as 17-bit limbs,
// then starts the multiplier and waits for it. Optional sticky err_o when MM_LOADER_ERR_EN is defined.
module mm_operand_loader #(
   parameter int WIDTH     = 256,
   parameter int OPERANDS  = 3,
   parameter int BASE_ADDR = 0
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic        load_i,
   input  logic [31:0] s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic [31:0] BRAM_addr_o,
   output logic [16:0] BRAM_din_o,
   output logic        BRAM_we_o,
   output logic        BRAM_en_o,
   output logic        start_o,
   input  logic        mm_done_i,
   output logic        busy_o,
   output logic        done_o
`ifdef MM_LOADER_ERR_EN
   ,
   output logic        err_o
`endif
);

   localparam int S         = (WIDTH + 1) / 17 + 1;
   localparam int NW        = (WIDTH + 31) / 32;
   localparam int TOTAL     = OPERANDS * S;
   localparam int LAST_BITS = WIDTH - 32 * (NW - 1);
   localparam int WC_W      = $clog2(NW + 1);
   localparam int LC_W      = $clog2(S + 1);
   localparam logic [63:0] MASK64    = (64'd1 << LAST_BITS) - 64'd1;
   localparam logic [31:0] LAST_MASK = MASK64[31:0];

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, FIN} state_t;

   state_t            state_q, state_d;
   logic [48:0]       buf_q, buf_d;
   logic [5:0]        fill_q, fill_after, fill_d;
   logic [WC_W-1:0]   word_cnt_q;
   logic [LC_W-1:0]   limb_cnt_q;
   logic [31:0]       idx_q;
   logic              last_wr_q;
   logic              in_load, words_left, loads_left, emit, accept, op_end;
   logic [31:0]       word_in;

   // Repack datapath: emit one limb per cycle from the low end, append accepted words above the fill.
   always_comb begin
      in_load    = (state_q == LOAD);
      words_left = (word_cnt_q < WC_W'(NW));
      loads_left = (idx_q < 32'(TOTAL));
      emit       = in_load && loads_left && ((fill_q >= 6'd17) || !words_left);
      op_end     = emit && (limb_cnt_q == LC_W'(S - 1));
      fill_after = fill_q;
      if (emit) fill_after = (fill_q > 6'd17) ? (fill_q - 6'd17) : 6'd0;
      s_ready_o  = in_load && loads_left && words_left && (fill_after <= 6'd17);
      accept     = s_ready_o && s_valid_i;
      word_in    = (word_cnt_q == WC_W'(NW - 1)) ? (s_data_i & LAST_MASK) : s_data_i;
      buf_d      = emit ? (buf_q >> 17) : buf_q;
      fill_d     = fill_after;
      if (accept) begin
         buf_d  = buf_d | ({17'd0, word_in} << fill_after);
         fill_d = fill_after + 6'd32;
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         buf_q      <= '0;
         fill_q     <= '0;
         word_cnt_q <= '0;
         limb_cnt_q <= '0;
         idx_q      <= '0;
         last_wr_q  <= 1'b0;
         BRAM_we_o  <= 1'b0;
         BRAM_addr_o <= '0;
         BRAM_din_o <= '0;
      end else begin
         BRAM_we_o <= emit;
         last_wr_q <= emit && (idx_q == 32'(TOTAL - 1));
         if (emit) begin
            BRAM_din_o  <= buf_q[16:0];
            BRAM_addr_o <= 32'(BASE_ADDR) + idx_q;
            idx_q       <= idx_q + 32'd1;
         end
         if (state_q == IDLE && load_i) idx_q <= '0;
         // Operand boundary: discard any leftover (zero) bits so nothing spills into the next operand.
         if (op_end) begin
            buf_q      <= '0;
            fill_q     <= '0;
            word_cnt_q <= '0;
            limb_cnt_q <= '0;
         end else begin
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            if (accept) word_cnt_q <= word_cnt_q + 1'b1;
            if (emit) limb_cnt_q <= limb_cnt_q + 1'b1;
         end
      end
   end

   // LOAD is left only once the final registered write has appeared on the BRAM port.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_i) state_d = LOAD;
         LOAD:    if (BRAM_we_o && last_wr_q) state_d = START;
         START:   state_d = WAIT;
         WAIT:    if (mm_done_i) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   assign BRAM_en_o = BRAM_we_o;
   assign start_o   = (state_q == START);
   assign done_o    = (state_q == FIN);
   assign busy_o    = (state_q != IDLE);

`ifdef MM_LOADER_ERR_EN
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i)
         err_o <= 1'b0;
      else if ((load_i && state_q != IDLE) || (mm_done_i && state_q != WAIT))
         err_o <= 1'b1;
      else if (load_i)
         err_o <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_mm_operand_loader.sv
// Bench for mm_operand_loader (WIDTH=256, OPERANDS=3, BASE_ADDR=0); err_o checks when MM_LOADER_ERR_EN is defined.
module tb_mm_operand_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        mm_done = 1'b0;
   logic        s_ready, we, en, start, busy, done;
   logic [31:0] addr;
   logic [16:0] din;
`ifdef MM_LOADER_ERR_EN
   logic        err;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0] wr_addr[$];
   logic [16:0] wr_din[$];
   int start_cnt = 0;
   int bad_cnt = 0;

   mm_operand_loader #(.WIDTH(256), .OPERANDS(3), .BASE_ADDR(0)) dut (
      .clock_i(clk), .reset_n_i(rst_n), .load_i(load),
      .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
      .BRAM_addr_o(addr), .BRAM_din_o(din), .BRAM_we_o(we), .BRAM_en_o(en),
      .start_o(start), .mm_done_i(mm_done), .busy_o(busy), .done_o(done)
`ifdef MM_LOADER_ERR_EN
      , .err_o(err)
`endif
   );

   always #5 clk = ~clk;

   // Write monitor: records every BRAM write and flags writes outside the loading phase.
   always @(negedge clk) begin
      if (rst_n) begin
         if (we) begin
            wr_addr.push_back(addr);
            wr_din.push_back(din);
         end
         if ((we !== en) || (we && (!busy || start || done))) bad_cnt++;
         if (start) start_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [16:0] ref_limb(input logic [255:0] v, input int k);
      logic [271:0] x;
      x = {16'd0, v};
      return x[17*k +: 17];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // mode 0: valid always high, 1: valid toggles 1-0-1-0, 2: random valid
   task automatic feed(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m,
                       input int mode, input int nmax, input int inject);
      logic [31:0] w[24];
      logic [255:0] ops[3];
      int n, cyc;
      logic hs;
      ops[0] = a; ops[1] = b; ops[2] = m;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 8; i++) w[j*8+i] = ops[j][32*i +: 32];
      n = 0; cyc = 0;
      while (n < nmax && cyc < 5000) begin
         @(negedge clk);
         s_data  = w[n];
         s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
         load    = (inject != 0) && (cyc == 7);
         mm_done = (inject != 0) && (cyc == 9);
         hs = s_valid && s_ready;
         @(posedge clk);
         if (hs) n++;
         cyc++;
      end
      @(negedge clk);
      s_valid = 1'b0; load = 1'b0; mm_done = 1'b0;
      if (cyc >= 5000) chk("feed_timeout", 64'(n), 64'(nmax));
   endtask

   // inject 1: stray load_i/mm_done_i during LOAD, inject 2: stray load_i during WAIT
   task automatic run(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m,
                      input int mode, input int delay, input int inject);
      int wb, sb, cyc, n;
      logic [255:0] ops[3];
      ops[0] = a; ops[1] = b; ops[2] = m;
      wb = wr_addr.size();
      sb = start_cnt;
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
      chk("busy_after_load", busy, 1);
`ifdef MM_LOADER_ERR_EN
      chk("err_cleared_by_load", err, 0);
`endif
      feed(a, b, m, mode, 24, (inject == 1) ? 1 : 0);
`ifdef MM_LOADER_ERR_EN
      if (inject == 1) chk("err_stray_in_load", err, 1);
`endif
      cyc = 0;
      while (!start && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("start_seen", start, 1);
      @(negedge clk);
      chk("start_one_cycle", start, 0);
      n = wr_addr.size() - wb;
      chk("write_count", 64'(n), 48);
      for (int i = 0; i < 48 && i < n; i++) begin
         chk($sformatf("addr[%0d]", i), wr_addr[wb+i], 64'(i));
         chk($sformatf("limb[%0d]", i), wr_din[wb+i], ref_limb(ops[i/16], i % 16));
      end
      chk("start_pulses", 64'(start_cnt - sb), 1);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         load = (inject == 2) && (i == 1);
      end
      load = 1'b0;
      chk("busy_in_wait", busy, 1);
      chk("no_done_in_wait", done, 0);
`ifdef MM_LOADER_ERR_EN
      if (inject == 2) chk("err_load_in_wait", err, 1);
`endif
      mm_done = 1'b1;
      @(negedge clk) mm_done = 1'b0;
      chk("done_pulse", done, 1);
      chk("busy_in_fin", busy, 1);
      @(negedge clk);
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
      chk("ready_idle", s_ready, 0);
   endtask

   initial begin
      logic [255:0] m34;
      m34 = (256'd1 << 255) | 256'd1;

      // Reset held for 3 cycles with a load pulse that must be ignored
      load = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", s_ready, 0);
      chk("rst_we", we, 0);
      chk("rst_en", en, 0);
      chk("rst_addr", addr, 0);
      chk("rst_din", din, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef MM_LOADER_ERR_EN
      chk("rst_err", err, 0);
`endif
      load = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", busy, 0);

      run(256'd1, 256'd2, m34, 0, 100, 0);
      run('1, rand256(), rand256(), 2, $urandom_range(3, 30), 0);
      run(256'd1, 256'd2, m34, 1, 10, 0);
      run(rand256(), rand256(), rand256(), 2, 20, 1);
      run(rand256(), rand256(), rand256(), 2, 5, 2);
      run(rand256(), '1, rand256(), 2, $urandom_range(1, 40), 0);

      // Reset after 5 accepted words, then a fresh load must start at address 0
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
      feed(rand256(), rand256(), rand256(), 0, 5, 0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midload_rst_busy", busy, 0);
      chk("midload_rst_we", we, 0);
      chk("midload_rst_ready", s_ready, 0);
      chk("midload_rst_addr", addr, 0);
      rst_n = 1'b1;
      run(rand256(), rand256(), rand256(), 2, 8, 0);

      // Reset while waiting on the multiplier
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
      feed(256'd5, 256'd6, 256'd7, 0, 24, 0);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midwait_rst_busy", busy, 0);
      chk("midwait_rst_start", start, 0);
      chk("midwait_rst_done", done, 0);
      rst_n = 1'b1;
      run(256'd1, 256'd2, m34, 2, 3, 0);

      chk("stray_write_events", 64'(bad_cnt), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
